// File: rtl/reg_ready_table.sv
// rtl/reg_ready_table.sv - register ready table with serialization drain handshake
module reg_ready_table #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rs1_idx,
    input  logic [IDX_W-1:0]    rs2_idx,
    output logic                rs1_ready,
    output logic                rs2_ready,
    input  logic                disp_valid,
    input  logic [IDX_W-1:0]    disp_rd,
    input  logic                wb0_valid,
    input  logic [IDX_W-1:0]    wb0_rd,
    input  logic                wb1_valid,
    input  logic [IDX_W-1:0]    wb1_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] ready_vec,
    input  logic                all_ready,
    input  logic                ser_req,
    output logic                ser_gnt,
    input  logic                ser_done,
    output logic                disp_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  gnt_q;
    logic [NUM_REGS-1:1]   ready_q;
    logic [NUM_REGS-1:1]   ready_d;
    logic [NUM_REGS-1:1]   disp_hit;
    logic [NUM_REGS-1:1]   wb_hit;
    logic                  disp_acc;
    logic                  rs1_bypass;
    logic                  rs2_bypass;

    assign disp_stall = (state_q != S_IDLE);
    assign disp_acc   = disp_valid && !disp_stall;

    // x0 has no storage; its bit is tied high so lookups and the AND see it ready.
    always_comb begin
        disp_hit = '0;
        wb_hit   = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            disp_hit[i] = disp_acc && (disp_rd == IDX_W'(i));
            wb_hit[i]   = (wb0_valid && (wb0_rd == IDX_W'(i))) ||
                          (wb1_valid && (wb1_rd == IDX_W'(i)));
        end
    end

    // A same-cycle dispatch clear beats writeback: the writeback is from the older producer.
    always_comb begin
        ready_d = (ready_q | wb_hit) & ~disp_hit;
        if (flush) begin
            ready_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= '1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready_vec = {ready_q, 1'b1};

    assign rs1_bypass = (wb0_valid && (wb0_rd == rs1_idx)) || (wb1_valid && (wb1_rd == rs1_idx));
    assign rs2_bypass = (wb0_valid && (wb0_rd == rs2_idx)) || (wb1_valid && (wb1_rd == rs2_idx));
    assign rs1_ready  = ready_vec[rs1_idx] || rs1_bypass;
    assign rs2_ready  = ready_vec[rs2_idx] || rs2_bypass;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ser_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (all_ready) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ser_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Grant is its own flop so it is glitch-free toward the serializing instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= (state_d == S_HOLD);
        end
    end

    assign ser_gnt = gnt_q;

endmodule

// File: doc/reg_ready_table.md
# reg_ready_table

Architectural register ready table for the dispatch stage: one ready bit per integer register, cleared when a producer dispatches and set when it writes back. The registered ready vector drives the `and32` reduction. `and32`'s single-bit output returns here as `all_ready` and gates a serialization handshake used by CSR, fence and other pipeline-draining instructions. Source-operand readiness lookups for dispatch are served from the same table.

## Interface
- `NUM_REGS`, 32: entries in the table; fixed at 32 to match the `and32` width.
- `IDX_W`, 5: register index width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs1_idx`  in  `IDX_W`  source 1 lookup index.
- `rs2_idx`  in  `IDX_W`  source 2 lookup index.
- `rs1_ready`  out  1  source 1 ready (combinational).
- `rs2_ready`  out  1  source 2 ready (combinational).
- `disp_valid`  in  1  a dispatching instruction writes `disp_rd`.
- `disp_rd`  in  `IDX_W`  destination of the dispatching instruction.
- `wb0_valid`, `wb1_valid`  in  1  writeback port valid.
- `wb0_rd`, `wb1_rd`  in  `IDX_W`  writeback destination.
- `flush`  in  1  pipeline flush; marks all registers ready.
- `ready_vec`  out  `NUM_REGS`  registered ready bits; drives `and32.a`.
- `all_ready`  in  1  from `and32.y`; equals `&ready_vec`.
- `ser_req`  in  1  serializing instruction at dispatch requests drain.
- `ser_gnt`  out  1  pipeline drained; serializing instruction may proceed (registered).
- `ser_done`  in  1  serializing instruction completed; release.
- `disp_stall`  out  1  dispatch must hold (combinational from state).

## Operation
- **Reset:**
  - `ready_vec` = 32'hFFFF_FFFF.
  - FSM = IDLE.
  - `ser_gnt` = 0, `disp_stall` = 0.
- **x0:** bit 0 is constant 1. Dispatch and writeback to rd = 0 are ignored. A lookup of index 0 returns ready.
- **Per-entry next state, in priority order:**
  1. `rst`: set to 1.
  2. `flush`: set to 1.
  3. Accepted dispatch to this rd: clear to 0.
  4. Either writeback to this rd: set to 1.
  5. Otherwise hold.
- **Same-cycle dispatch and writeback to the same rd:** the clear wins, because the writeback belongs to the older producer.
- **Both writeback ports to the same rd:** set to 1; not an error.
- **Dispatch acceptance:** dispatch is accepted only when `disp_valid` = 1 and `disp_stall` = 0. `disp_valid` during a stall is ignored and does not change state.
- **Lookups:** `rsN_ready` = `ready_vec[rsN_idx]` OR (`wb0_valid` && `wb0_rd` == `rsN_idx`) OR (`wb1_valid` && `wb1_rd` == `rsN_idx`).
  - Same-cycle writeback is bypassed into the lookup.
  - A same-cycle dispatch clear is not visible until the next cycle.
- **Serialization FSM:**
  - IDLE: `ser_req` → DRAIN. Otherwise stay.
  - DRAIN: `disp_stall` = 1. `all_ready` = 1 → HOLD and `ser_gnt` goes to 1. Otherwise stay.
  - HOLD: `disp_stall` = 1, `ser_gnt` = 1. `ser_done` → IDLE and `ser_gnt` goes to 0.
  - `flush` in any state → IDLE and `ser_gnt` goes to 0 on the next edge. Flush overrides `ser_req`, `ser_done` and `all_ready`.
  - `ser_req` in DRAIN or HOLD is ignored.
  - `ser_done` in IDLE or DRAIN is ignored.
- **Mid-operation reset:** `rst` in any state behaves as a reset on the next edge: all bits 1, FSM IDLE, `ser_gnt` = 0.

## Timing
- **`ready_vec`:** updates one cycle after the dispatch, writeback or flush that causes the change.
- **`all_ready`:** combinational from the registered `ready_vec`. No combinational path from any input to `all_ready` through this block.
- **`disp_stall`:** decoded from the FSM state only.
  - Asserted the cycle after `ser_req` is sampled.
  - Deasserted the cycle after `ser_done` or `flush` is sampled.
- **Grant latency:**
  - Minimum: `ser_req` sampled at edge t with the table fully ready gives `ser_gnt` = 1 after edge t+1 (2 cycles).
  - Otherwise: one cycle after the last outstanding writeback lands.
- **Release:** `ser_gnt` falls one edge after `ser_done`.
- Writebacks continue during DRAIN and HOLD.

## Test plan
- **Reset and flush:**
  - Assert `rst` for one cycle → `ready_vec` = FFFF_FFFF, `ser_gnt` = 0, `disp_stall` = 0, `all_ready` = 1.
  - Dispatch rd = 5 and rd = 9, then `flush` → `ready_vec` = FFFF_FFFF on the next cycle.
- **Dispatch and writeback:**
  - Dispatch rd = 7 → next cycle `ready_vec` = FFFF_FF7F, `all_ready` = 0.
  - Writeback `wb1_rd` = 7 → next cycle FFFF_FFFF.
  - Dispatch rd = 0 → no change.
- **Collision:**
  - Same cycle: dispatch rd = 3 with `wb0_rd` = 3 → bit 3 = 0 next cycle.
  - `wb0_rd` = `wb1_rd` = 3 → bit 3 = 1.
- **Bypass:**
  - Bit 12 = 0, `rs1_idx` = 12, `wb0_valid` = 1, `wb0_rd` = 12 → `rs1_ready` = 1 in the same cycle.
  - `rs2_idx` = 0 → `rs2_ready` = 1 always.
- **Serialize:**
  - Starting from bit 4 = 0, pulse `ser_req` → `disp_stall` = 1, `ser_gnt` stays 0.
  - `disp_valid` rd = 6 during the stall → bit 6 unchanged.
  - Writeback rd = 4 → `ser_gnt` = 1 one cycle after `ready_vec` returns to FFFF_FFFF.
  - `ser_done` → `ser_gnt` = 0 and `disp_stall` = 0 next cycle.
- **Abort:**
  - Flush during DRAIN → next cycle IDLE, `ser_gnt` = 0, `disp_stall` = 0.
  - `rst` during HOLD → same result.
  - Random dispatch/writeback soak (1000 cycles) against a reference model of the ready bits and `all_ready` = &bits.
